// File: rtl/result_drain_pkg.sv
// rtl/result_drain_pkg.sv - shared fixed-point format types and limit helpers
package result_drain_pkg;

    typedef struct packed {
        int width;
        int frac;
    } fxp_fmt_t;

    function automatic longint sat_limit_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_limit_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/result_drain_fxp_requant.sv
// rtl/result_drain_fxp_requant.sv - combinational fixed-point requantizer with round-half-up and saturation
module fxp_requant
    import result_drain_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int IN_FRAC   = 10,
    parameter int OUT_WIDTH = 8,
    parameter int OUT_FRAC  = 4
) (
    input  logic [IN_WIDTH-1:0]  i_data,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic                 o_sat
);

    localparam int SHIFT = IN_FRAC - OUT_FRAC;
    localparam int RSH   = (SHIFT > 0) ? SHIFT : 0;
    localparam int LSH   = (SHIFT < 0) ? -SHIFT : 0;
    // One guard bit keeps the rounding add from overflowing; also wide enough for clamp compares
    localparam int WA    = IN_WIDTH + LSH + 1;
    localparam int WW    = (WA > OUT_WIDTH + 1) ? WA : OUT_WIDTH + 1;

    localparam logic signed [WW-1:0] MAXV = WW'(sat_limit_max(OUT_WIDTH));
    localparam logic signed [WW-1:0] MINV = WW'(sat_limit_min(OUT_WIDTH));

    logic signed [WW-1:0] w_ext;
    logic signed [WW-1:0] w_res;

    assign w_ext = {{(WW - IN_WIDTH){i_data[IN_WIDTH-1]}}, i_data};

    generate
        if (RSH > 0) begin : g_round
            localparam logic signed [WW-1:0] RND = WW'(1) <<< (RSH - 1);
            assign w_res = (w_ext + RND) >>> RSH;
        end else begin : g_shl
            assign w_res = w_ext <<< LSH;
        end
    endgenerate

    always_comb begin
        o_data = w_res[OUT_WIDTH-1:0];
        o_sat  = 1'b0;
        if (w_res > MAXV) begin
            o_data = MAXV[OUT_WIDTH-1:0];
            o_sat  = 1'b1;
        end else if (w_res < MINV) begin
            o_data = MINV[OUT_WIDTH-1:0];
            o_sat  = 1'b1;
        end
    end

endmodule

// File: rtl/result_drain.sv
// rtl/result_drain.sv - captures done-qualified results, requantizes, buffers in a FWFT FIFO with stall back-pressure
module result_drain
    import result_drain_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int IN_FRAC   = 10,
    parameter int OUT_WIDTH = 8,
    parameter int OUT_FRAC  = 4,
    parameter int DEPTH     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [IN_WIDTH-1:0]    in_data,
    input  logic                   in_done,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   stall_req,
    output logic [OUT_WIDTH-1:0]   m_data,
    output logic                   m_sat,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = occ_width(DEPTH);

    logic [OUT_WIDTH:0]   r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 r_full;
    logic                 r_valid;

    logic [OUT_WIDTH-1:0] w_q_data;
    logic                 w_q_sat;
    logic                 w_push;
    logic                 w_pop;
    logic [CW-1:0]        w_count_next;

    fxp_requant #(
        .IN_WIDTH  (IN_WIDTH),
        .IN_FRAC   (IN_FRAC),
        .OUT_WIDTH (OUT_WIDTH),
        .OUT_FRAC  (OUT_FRAC)
    ) u_requant (
        .i_data (in_data),
        .o_data (w_q_data),
        .o_sat  (w_q_sat)
    );

    // Stall gates the push so a done held by a frozen producer is captured only once
    assign w_push = in_done && !stall && !r_full;
    assign w_pop  = r_valid && m_ready;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_valid  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_q_sat, w_q_data};
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CW'(DEPTH));
            r_valid <= (w_count_next != '0);
        end
    end

    assign stall_req = r_full;
    assign m_valid   = r_valid;
    assign count     = r_count;
    assign m_data    = r_mem[r_rd_ptr][OUT_WIDTH-1:0];
    assign m_sat     = r_mem[r_rd_ptr][OUT_WIDTH];

endmodule

// File: tb/tb_result_drain.sv
// tb/tb_result_drain.sv - directed vector bench for result_drain
module tb_result_drain;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_done;
    logic        stall;
    logic        flush;
    logic        stall_req;
    logic [7:0]  m_data;
    logic        m_sat;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  count;

    logic        ext_stall;
    logic        loop_stall;

    int n_checks = 0;
    int n_pass   = 0;

    assign stall = ext_stall | (loop_stall & stall_req);

    always #5 clk = ~clk;

    result_drain dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_done   (in_done),
        .stall     (stall),
        .flush     (flush),
        .stall_req (stall_req),
        .m_data    (m_data),
        .m_sat     (m_sat),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .count     (count)
    );

    typedef struct {
        int din;
        int exp_data;
        int exp_sat;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input int val);
        in_done = 1'b1;
        in_data = 16'(val);
        step();
        in_done = 1'b0;
    endtask

    vec_t vecs[7];
    int   exp_q[$];
    int   got_q[$];
    int   j;
    bit   st;
    bit   popped;
    int   d;
    bit   first_pop_seen;

    initial begin
        vecs[0] = '{1536, 24, 0};
        vecs[1] = '{1568, 25, 0};
        vecs[2] = '{1544, 24, 0};
        vecs[3] = '{-1, 0, 0};
        vecs[4] = '{16384, 127, 1};
        vecs[5] = '{-16384, -128, 1};
        vecs[6] = '{-8192, -128, 0};

        reset = 1'b1; in_data = '0; in_done = 1'b0; flush = 1'b0;
        m_ready = 1'b0; ext_stall = 1'b0; loop_stall = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("reset_count", int'(count), 0);
        chk("reset_valid", int'(m_valid), 0);
        chk("reset_stall_req", int'(stall_req), 0);
        chk("reset_data", int'(m_data), 0);
        chk("reset_sat", int'(m_sat), 0);

        // Requantization vectors: each pushed word is visible right after its edge
        m_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_done = 1'b1;
            in_data = 16'(vecs[i].din);
            step();
            chk($sformatf("vec%0d_valid", i), int'(m_valid), 1);
            chk($sformatf("vec%0d_data", i), int'($signed(m_data)), vecs[i].exp_data);
            chk($sformatf("vec%0d_sat", i), int'(m_sat), vecs[i].exp_sat);
            chk($sformatf("vec%0d_count", i), int'(count), 1);
        end
        in_done = 1'b0;
        step();
        chk("drain_count", int'(count), 0);
        chk("drain_valid", int'(m_valid), 0);

        // Fill with producer stalled by our own stall_req
        m_ready = 1'b0;
        loop_stall = 1'b1;
        j = 0;
        for (int c = 0; c < 10; c++) begin
            in_done = 1'b1;
            in_data = 16'(64 * (j + 1));
            st = stall;
            step();
            if (!st) j++;
        end
        chk("fill_count", int'(count), 8);
        chk("fill_stall_req", int'(stall_req), 1);
        chk("fill_pushes", j, 8);

        m_ready = 1'b1;
        first_pop_seen = 1'b0;
        got_q.delete();
        for (int c = 0; c < 30 && got_q.size() < 9; c++) begin
            in_done = (j < 9);
            in_data = 16'(64 * (j + 1));
            st = stall;
            popped = m_valid;
            d = int'($signed(m_data));
            step();
            if (popped) got_q.push_back(d);
            if (in_done && !st) j++;
            if (popped && !first_pop_seen) begin
                first_pop_seen = 1'b1;
                chk("stall_req_drop", int'(stall_req), 0);
                chk("count_after_first_pop", int'(count), 7);
            end
        end
        in_done = 1'b0;
        chk("fill_drain_size", got_q.size(), 9);
        for (int i = 0; i < got_q.size(); i++) chk($sformatf("fill_order%0d", i), got_q[i], i + 1);
        chk("fill_end_count", int'(count), 0);
        loop_stall = 1'b0;

        // Held done under external stall must be captured exactly once
        m_ready = 1'b0;
        ext_stall = 1'b1;
        in_done = 1'b1;
        in_data = 16'(64 * 20);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("held_count%0d", c), int'(count), 0);
        end
        ext_stall = 1'b0;
        step();
        in_done = 1'b0;
        chk("held_release_count", int'(count), 1);
        step();
        chk("held_no_dup", int'(count), 1);
        chk("held_data", int'($signed(m_data)), 20);

        // Simultaneous push/pop at count=3 across pointer wrap
        exp_q.delete();
        exp_q.push_back(20);
        push_one(64 * 21); exp_q.push_back(21);
        push_one(64 * 22); exp_q.push_back(22);
        chk("pp_start_count", int'(count), 3);
        m_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_done = 1'b1;
            in_data = 16'(64 * (23 + c));
            step();
            void'(exp_q.pop_front());
            exp_q.push_back(23 + c);
            chk($sformatf("pp_count%0d", c), int'(count), 3);
            chk($sformatf("pp_head%0d", c), int'($signed(m_data)), exp_q[0]);
        end
        in_done = 1'b0;
        m_ready = 1'b0;

        // Flush at count=5 with a coincident push
        push_one(64 * 30);
        push_one(64 * 31);
        chk("pre_flush_count", int'(count), 5);
        flush = 1'b1;
        in_done = 1'b1;
        in_data = 16'(64 * 32);
        step();
        flush = 1'b0;
        in_done = 1'b0;
        chk("flush_count", int'(count), 0);
        chk("flush_valid", int'(m_valid), 0);
        step();
        chk("flush_push_dropped", int'(count), 0);

        // Reset at count=4
        for (int c = 0; c < 4; c++) push_one(64 * (40 + c));
        chk("pre_reset_count", int'(count), 4);
        reset = 1'b1;
        m_ready = 1'b1;
        in_done = 1'b1;
        step();
        reset = 1'b0;
        in_done = 1'b0;
        chk("rst2_count", int'(count), 0);
        chk("rst2_valid", int'(m_valid), 0);
        chk("rst2_data", int'(m_data), 0);
        chk("rst2_sat", int'(m_sat), 0);
        chk("rst2_stall_req", int'(stall_req), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
